mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns each load/store into a registered req/ack transaction on the data bus and drives the stall (`pipeline_stop_o`) back to all upstream pipeline registers until the access completes.
- Selects the writeback value and holds the MEM/WB pipeline register, inserting bubbles while stalled.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in REQ without dbus_ack_i before the access is abandoned; range 1..65535.
- ERR_RDATA, 32'hDEAD_BEEF: load data substituted on timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mem_reg_write_i  in  2  writeback source: 00 resC, 01 load data, 10 pc4, 11 ext
- mem_mem_write_i  in  2  store kind: 00 none, 01 store word, 10 store byte, 11 reserved (no store)
- mem_reg_we_i  in  1  register write enable
- mem_resC_i  in  32  ALU result / memory address
- mem_rD2_i  in  32  store data
- mem_ext_i  in  32  immediate
- mem_pc4_i  in  32  PC+4
- mem_wR_i  in  5  destination register
- mem_debug_wb_have_inst_i  in  1  instruction-valid tag
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  1 = write
- dbus_addr_o  out  32  word-aligned address
- dbus_wdata_o  out  32  write data
- dbus_wstrb_o  out  4  byte strobes
- dbus_ack_i  in  1  single-cycle completion pulse
- dbus_rdata_i  in  32  read data, valid with ack
- pipeline_stop_o  out  1  stall to PC/IF_ID/ID_EX/EX_MEM registers
- bus_err_o  out  1  sticky timeout flag
- wb_reg_we_o  out  1  MEM/WB reg write enable
- wb_wR_o  out  5  MEM/WB destination
- wb_wD_o  out  32  MEM/WB write data
- wb_debug_have_inst_o  out  1  MEM/WB valid tag

Behaviour:
- `op_valid = mem_debug_wb_have_inst_i & (mem_reg_write_i==01 | mem_mem_write_i==01 | mem_mem_write_i==10)`.
- A store takes priority for `dbus_we_o`. If both load and store are encoded, the access is a store and the writeback uses `ERR_RDATA`.

FSM states IDLE, REQ, DONE. Reset state is IDLE.
- IDLE: if `op_valid`, latch address `{resC[31:2],2'b00}`, wdata and wstrb, then go to REQ.
- REQ: `dbus_req_o`=1; address, data, strobes and we stay stable.
  - On `dbus_ack_i`: latch `dbus_rdata_i` (loads only) and go to DONE.
  - If the timeout counter reaches `TIMEOUT_CYCLES` with no ack: set `bus_err_o`, latch `ERR_RDATA`, go to DONE.
- DONE: unconditionally return to IDLE after one cycle.
- The same-cycle ack and timeout case resolves to ack.

`pipeline_stop_o` (combinational) = `(IDLE & op_valid) | REQ`. It is 0 in DONE, so EX/MEM advances at the end of the DONE cycle. This guarantees no re-issue of the completed op.
- Latency: a load or store stalls for 1 (IDLE) + N (REQ, N ≥ 1 until ack) cycles. The writeback then registers at the end of DONE.
- Non-memory instructions pass with zero stall.

Byte store:
- `wstrb = 4'b0001 << resC[1:0]`
- `wdata = {4{rD2[7:0]}}`

Word store:
- `wstrb = 4'b1111`
- `wdata = rD2`
- `resC[1:0]` is ignored.

Writeback path (wb_* registers):
- Reset: all wb_* outputs are 0, `bus_err_o`=0.
- Every cycle with `pipeline_stop_o`=1, load a bubble: `wb_reg_we_o`=0, `wb_debug_have_inst_o`=0, `wb_wR_o`=0, `wb_wD_o`=0.
- Otherwise load `mem_reg_we_i`, `mem_wR_i`, `mem_debug_wb_have_inst_i`, and `wb_wD_o` by source:
  - 00: resC
  - 01: latched rdata
  - 10: pc4
  - 11: ext

Timeout counter:
- 16 bits; cleared when entering REQ, increments each REQ cycle, saturates.

`bus_err_o` stays set until rst_n.

Reset mid-operation: `dbus_req_o` and `pipeline_stop_o` drop asynchronously; the FSM returns to IDLE; no writeback occurs.

A late ack arriving in IDLE or DONE is ignored.

Decomposition:
- Shared package (`cpu_pkg`): WB_SRC_{RESC,MEM,PC4,EXT} 2-bit constants, ST_{NONE,WORD,BYTE} constants, FSM state enum.
- One sub-module is natural: `mem_wb_reg` (stall→bubble register for the wb_* outputs). The FSM and strobe logic stay in the top level.

Test Plan:
- ALU op (reg_write=00, resC=32'h1234, wR=5, have_inst=1), no memory op → `pipeline_stop_o`=0 throughout; next cycle `wb_wD_o`=32'h1234, `wb_wR_o`=5, `wb_reg_we_o`=1.
- Load, resC=32'h103, ack 3 cycles after req with rdata=32'hCAFEF00D:
  - `dbus_addr_o`=32'h100, `dbus_we_o`=0, `pipeline_stop_o` high for 4 cycles.
  - wb bubbles during the stall, then `wb_wD_o`=32'hCAFEF00D exactly once.
- Byte store, resC=32'h202, rD2=32'hAB → `dbus_wstrb_o`=4'b0100, `dbus_wdata_o`=32'hABABABAB, `dbus_we_o`=1.
- Back-to-back loads with ack on the first REQ cycle → each load issues exactly one req; 2 stall cycles each; no duplicate writeback.
- TIMEOUT_CYCLES=4, no ack → after 4 REQ cycles `bus_err_o`=1, `wb_wD_o`=32'hDEADBEEF, pipeline resumes; a late ack is ignored.
- rst_n asserted during REQ → `dbus_req_o`, `pipeline_stop_o` and all wb_* outputs are 0 immediately; after release a new load issues normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared MEM-stage encodings: writeback source select, store kind, FSM states.
// Also carries the MEM/WB payload struct so the stage and its pipeline register agree on layout.
package cpu_pkg;
    localparam logic [1:0] WB_SRC_RESC = 2'b00;
    localparam logic [1:0] WB_SRC_MEM  = 2'b01;
    localparam logic [1:0] WB_SRC_PC4  = 2'b10;
    localparam logic [1:0] WB_SRC_EXT  = 2'b11;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_WORD = 2'b01;
    localparam logic [1:0] ST_BYTE = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} mem_state_t;

    typedef struct packed {
        logic        reg_we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        have_inst;
    } wb_bus_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: one-cycle latency, loads the incoming payload each cycle.
// While stalled it loads an all-zero bubble instead of holding, so a stalled op never writes back twice.
module mem_wb_reg
    import cpu_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    stall,
    input  wb_bus_t d,
    output wb_bus_t q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (stall) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: turns loads/stores into a req/ack bus access and stalls upstream until it completes.
// Latency 1 + N cycles of stall per access (N REQ cycles), writeback registered at the end of DONE.
module mem_stage_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mem_reg_write_i,
    input  logic [1:0]  mem_mem_write_i,
    input  logic        mem_reg_we_i,
    input  logic [31:0] mem_resC_i,
    input  logic [31:0] mem_rD2_i,
    input  logic [31:0] mem_ext_i,
    input  logic [31:0] mem_pc4_i,
    input  logic [4:0]  mem_wR_i,
    input  logic        mem_debug_wb_have_inst_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [31:0] dbus_addr_o,
    output logic [31:0] dbus_wdata_o,
    output logic [3:0]  dbus_wstrb_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        pipeline_stop_o,
    output logic        bus_err_o,
    output logic        wb_reg_we_o,
    output logic [4:0]  wb_wR_o,
    output logic [31:0] wb_wD_o,
    output logic        wb_debug_have_inst_o
);
    mem_state_t  state;
    logic        is_load;
    logic        is_store;
    logic        op_valid;
    logic        tmo_hit;
    logic [15:0] tmo_cnt;
    logic [31:0] mem_rdata;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    wb_bus_t     wb_d;
    wb_bus_t     wb_q;

    assign is_load  = (mem_reg_write_i == WB_SRC_MEM);
    assign is_store = (mem_mem_write_i == ST_WORD) || (mem_mem_write_i == ST_BYTE);
    assign op_valid = mem_debug_wb_have_inst_i & (is_load | is_store);
    // Fires on the TIMEOUT_CYCLES-th REQ cycle, counter holds completed REQ cycles
    assign tmo_hit  = ({1'b0, tmo_cnt} + 17'd1) >= 17'(TIMEOUT_CYCLES);

    always_comb begin
        st_strb = 4'b1111;
        st_data = mem_rD2_i;
        if (mem_mem_write_i == ST_BYTE) begin
            st_strb = 4'b0001 << mem_resC_i[1:0];
            st_data = {4{mem_rD2_i[7:0]}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= '0;
            dbus_wdata_o <= '0;
            dbus_wstrb_o <= '0;
            tmo_cnt      <= '0;
            mem_rdata    <= '0;
            bus_err_o    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        state        <= S_REQ;
                        dbus_req_o   <= 1'b1;
                        dbus_we_o    <= is_store;
                        dbus_addr_o  <= {mem_resC_i[31:2], 2'b00};
                        dbus_wdata_o <= is_store ? st_data : '0;
                        dbus_wstrb_o <= is_store ? st_strb : 4'b0000;
                        tmo_cnt      <= '0;
                    end
                end
                S_REQ: begin
                    // Ack wins over a coincident timeout; a load+store encoding writes back ERR_RDATA
                    if (dbus_ack_i) begin
                        state      <= S_DONE;
                        dbus_req_o <= 1'b0;
                        mem_rdata  <= dbus_we_o ? ERR_RDATA : dbus_rdata_i;
                    end else if (tmo_hit) begin
                        state      <= S_DONE;
                        dbus_req_o <= 1'b0;
                        bus_err_o  <= 1'b1;
                        mem_rdata  <= ERR_RDATA;
                    end else if (tmo_cnt != 16'hFFFF) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Gated by rst_n so the stall drops immediately on reset even with a valid op held upstream
    assign pipeline_stop_o = rst_n & (((state == S_IDLE) & op_valid) | (state == S_REQ));

    always_comb begin
        wb_d           = '0;
        wb_d.reg_we    = mem_reg_we_i;
        wb_d.wr        = mem_wR_i;
        wb_d.have_inst = mem_debug_wb_have_inst_i;
        case (mem_reg_write_i)
            WB_SRC_RESC: wb_d.wd = mem_resC_i;
            WB_SRC_MEM:  wb_d.wd = mem_rdata;
            WB_SRC_PC4:  wb_d.wd = mem_pc4_i;
            default:     wb_d.wd = mem_ext_i;
        endcase
    end

    mem_wb_reg u_mem_wb_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (pipeline_stop_o),
        .d     (wb_d),
        .q     (wb_q)
    );

    assign wb_reg_we_o          = wb_q.reg_we;
    assign wb_wR_o              = wb_q.wr;
    assign wb_wD_o              = wb_q.wd;
    assign wb_debug_have_inst_o = wb_q.have_inst;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: an EX/MEM driver holding each op while stalled, a bus slave, and a wb scoreboard.
module tb_mem_stage_ctrl;
    import cpu_pkg::*;

    localparam int          TMO = 4;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    typedef struct {
        logic [1:0]  rw;
        logic [1:0]  mw;
        logic        we;
        logic        hi;
        logic [4:0]  wr;
        logic [31:0] resc;
        logic [31:0] rd2;
        logic [31:0] ext;
        logic [31:0] pc4;
        logic [31:0] rdata;
        int          ack_dly;   // REQ cycle carrying the ack, 0 = slave never answers
    } instr_t;

    typedef struct {
        logic        we;
        logic        hi;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mem_reg_write_i;
    logic [1:0]  mem_mem_write_i;
    logic        mem_reg_we_i;
    logic [31:0] mem_resC_i;
    logic [31:0] mem_rD2_i;
    logic [31:0] mem_ext_i;
    logic [31:0] mem_pc4_i;
    logic [4:0]  mem_wR_i;
    logic        mem_debug_wb_have_inst_i;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [31:0] dbus_wdata_o;
    logic [3:0]  dbus_wstrb_o;
    logic        dbus_ack_i;
    logic [31:0] dbus_rdata_i;
    logic        pipeline_stop_o;
    logic        bus_err_o;
    logic        wb_reg_we_o;
    logic [4:0]  wb_wR_o;
    logic [31:0] wb_wD_o;
    logic        wb_debug_have_inst_o;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERR)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .mem_reg_write_i          (mem_reg_write_i),
        .mem_mem_write_i          (mem_mem_write_i),
        .mem_reg_we_i             (mem_reg_we_i),
        .mem_resC_i               (mem_resC_i),
        .mem_rD2_i                (mem_rD2_i),
        .mem_ext_i                (mem_ext_i),
        .mem_pc4_i                (mem_pc4_i),
        .mem_wR_i                 (mem_wR_i),
        .mem_debug_wb_have_inst_i (mem_debug_wb_have_inst_i),
        .dbus_req_o               (dbus_req_o),
        .dbus_we_o                (dbus_we_o),
        .dbus_addr_o              (dbus_addr_o),
        .dbus_wdata_o             (dbus_wdata_o),
        .dbus_wstrb_o             (dbus_wstrb_o),
        .dbus_ack_i               (dbus_ack_i),
        .dbus_rdata_i             (dbus_rdata_i),
        .pipeline_stop_o          (pipeline_stop_o),
        .bus_err_o                (bus_err_o),
        .wb_reg_we_o              (wb_reg_we_o),
        .wb_wR_o                  (wb_wR_o),
        .wb_wD_o                  (wb_wD_o),
        .wb_debug_have_inst_o     (wb_debug_have_inst_o)
    );

    int     n_checks = 0;
    int     n_pass   = 0;
    int     req_starts = 0;
    int     req_cyc = 0;
    bit     prev_req = 0;
    bit     mon_en = 0;
    bit     stop_s = 1;
    bit     err_model = 0;
    instr_t cur;
    exp_t   exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit f_st(input instr_t t);
        return t.hi && (t.mw == ST_WORD || t.mw == ST_BYTE);
    endfunction

    function automatic bit f_ld(input instr_t t);
        return t.hi && (t.rw == WB_SRC_MEM);
    endfunction

    function automatic int f_stall(input instr_t t);
        if (!(f_st(t) || f_ld(t))) return 0;
        return 1 + ((t.ack_dly == 0) ? TMO : t.ack_dly);
    endfunction

    function automatic instr_t mk(input logic [1:0] rw, input logic [1:0] mw, input logic we,
                                  input logic hi, input logic [4:0] wr, input logic [31:0] resc,
                                  input logic [31:0] rd2, input int ack_dly, input logic [31:0] rdata);
        instr_t t;
        t.rw = rw; t.mw = mw; t.we = we; t.hi = hi; t.wr = wr;
        t.resc = resc; t.rd2 = rd2; t.ack_dly = ack_dly; t.rdata = rdata;
        t.ext = $urandom;
        t.pc4 = $urandom & 32'hFFFF_FFFC;
        return t;
    endfunction

    // Present one op as the EX/MEM register would, hold it while stalled, check stall and req counts
    task automatic run_one(input instr_t t);
        int   stalls;
        exp_t e;
        bit   mem;
        mem = f_st(t) || f_ld(t);
        if (mem && t.ack_dly == 0) err_model = 1;
        e.we = t.we; e.hi = t.hi; e.wr = t.wr; e.err = err_model;
        case (t.rw)
            2'b00:   e.wd = t.resc;
            2'b01:   e.wd = (f_st(t) || t.ack_dly == 0) ? ERR : t.rdata;
            2'b10:   e.wd = t.pc4;
            default: e.wd = t.ext;
        endcase
        exp_q.push_back(e);
        cur = t;
        req_starts = 0;
        stalls = 0;
        mem_reg_write_i = t.rw; mem_mem_write_i = t.mw; mem_reg_we_i = t.we;
        mem_resC_i = t.resc; mem_rD2_i = t.rd2; mem_ext_i = t.ext; mem_pc4_i = t.pc4;
        mem_wR_i = t.wr; mem_debug_wb_have_inst_i = t.hi;
        #1 stop_s = pipeline_stop_o;
        mon_en = 1;
        while (stop_s) begin
            stalls++;
            if (stalls > 40) begin
                n_checks++;
                $display("FAIL stall_bound: stall still high after %0d cycles, required %0d", stalls, f_stall(t));
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $fatal(1, "bench aborted");
            end
            @(negedge clk);
            #1 stop_s = pipeline_stop_o;
        end
        chk("stall_cycles", 64'(stalls), 64'(f_stall(t)));
        @(negedge clk);
        chk("req_count", 64'(req_starts), mem ? 64'd1 : 64'd0);
    endtask

    // Bus slave: acks on the op's chosen REQ cycle, throws stray acks outside REQ
    initial begin
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        dbus_ack_i = 1'b0;
        dbus_rdata_i = '0;
        forever begin
            @(negedge clk);
            #2;
            dbus_ack_i = 1'b0;
            dbus_rdata_i = $urandom;
            if (dbus_req_o) begin
                if (!prev_req) req_starts++;
                req_cyc++;
                chk("bus_addr", 64'(dbus_addr_o), 64'({cur.resc[31:2], 2'b00}));
                chk("bus_we", 64'(dbus_we_o), 64'(f_st(cur)));
                if (f_st(cur)) begin
                    exp_strb  = (cur.mw == ST_BYTE) ? 4'(1 << cur.resc[1:0]) : 4'hF;
                    exp_wdata = (cur.mw == ST_BYTE) ? {4{cur.rd2[7:0]}} : cur.rd2;
                    chk("bus_wstrb", 64'(dbus_wstrb_o), 64'(exp_strb));
                    chk("bus_wdata", 64'(dbus_wdata_o), 64'(exp_wdata));
                end
                if (req_cyc == cur.ack_dly) begin
                    dbus_ack_i = 1'b1;
                    dbus_rdata_i = cur.rdata;
                end
            end else begin
                req_cyc = 0;
                if ((prev_req && cur.ack_dly == 0) || $urandom_range(0, 3) == 0) dbus_ack_i = 1'b1;
            end
            prev_req = dbus_req_o;
        end
    end

    // Scoreboard monitor: a stalled edge must load a bubble, an advancing edge pops one expected writeback
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && rst_n) begin
                if (stop_s) begin
                    chk("wb_bubble", 64'({wb_reg_we_o, wb_debug_have_inst_o, wb_wR_o, wb_wD_o}), 64'd0);
                end else if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL wb_extra: writeback with no op issued, wD=%0h", wb_wD_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_wD", 64'(wb_wD_o), 64'(e.wd));
                    chk("wb_wR", 64'(wb_wR_o), 64'(e.wr));
                    chk("wb_reg_we", 64'(wb_reg_we_o), 64'(e.we));
                    chk("wb_have_inst", 64'(wb_debug_have_inst_o), 64'(e.hi));
                    chk("bus_err", 64'(bus_err_o), 64'(e.err));
                end
            end
        end
    end

    initial begin
        instr_t t;
        int     a;
        logic [1:0] rw;
        logic       hi;
        rst_n = 1'b0;
        mem_reg_write_i = '0; mem_mem_write_i = '0; mem_reg_we_i = 1'b0;
        mem_resC_i = '0; mem_rD2_i = '0; mem_ext_i = '0; mem_pc4_i = '0;
        mem_wR_i = '0; mem_debug_wb_have_inst_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", 64'(dbus_req_o), 64'd0);
        chk("rst_stop", 64'(pipeline_stop_o), 64'd0);
        chk("rst_bus_err", 64'(bus_err_o), 64'd0);
        chk("rst_wb", 64'({wb_reg_we_o, wb_debug_have_inst_o, wb_wR_o, wb_wD_o}), 64'd0);
        rst_n = 1'b1;

        run_one(mk(WB_SRC_RESC, ST_NONE, 1'b1, 1'b1, 5'd5, 32'h1234, 32'h0, 1, 32'h0));
        run_one(mk(WB_SRC_MEM, ST_NONE, 1'b1, 1'b1, 5'd9, 32'h103, 32'h0, 3, 32'hCAFE_F00D));
        run_one(mk(WB_SRC_RESC, ST_BYTE, 1'b0, 1'b1, 5'd0, 32'h202, 32'hAB, 2, 32'h0));
        run_one(mk(WB_SRC_MEM, ST_NONE, 1'b1, 1'b1, 5'd3, 32'h500, 32'h0, 1, 32'h1111_0001));
        run_one(mk(WB_SRC_MEM, ST_NONE, 1'b1, 1'b1, 5'd4, 32'h504, 32'h0, 1, 32'h2222_0002));
        run_one(mk(WB_SRC_MEM, ST_NONE, 1'b1, 1'b1, 5'd6, 32'h600, 32'h0, 0, 32'h3333_0003));
        run_one(mk(WB_SRC_PC4, ST_WORD, 1'b1, 1'b1, 5'd7, 32'h703, 32'h8765_4321, 1, 32'h0));

        // Reset while the bus request is outstanding
        t = mk(WB_SRC_MEM, ST_NONE, 1'b1, 1'b1, 5'd8, 32'h400, 32'h0, 3, 32'h1111_2222);
        exp_q.push_back('{we: 1'b1, hi: 1'b1, wr: 5'd8, wd: 32'h1111_2222, err: err_model});
        cur = t;
        req_starts = 0;
        mem_reg_write_i = t.rw; mem_mem_write_i = t.mw; mem_reg_we_i = t.we;
        mem_resC_i = t.resc; mem_rD2_i = t.rd2; mem_wR_i = t.wr; mem_debug_wb_have_inst_i = t.hi;
        #1 stop_s = pipeline_stop_o;
        @(negedge clk);
        #1 stop_s = pipeline_stop_o;
        chk("pre_rst_req", 64'(dbus_req_o), 64'd1);
        #2;
        mon_en = 0;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 64'(dbus_req_o), 64'd0);
        chk("midrst_stop", 64'(pipeline_stop_o), 64'd0);
        chk("midrst_bus_err", 64'(bus_err_o), 64'd0);
        chk("midrst_wb", 64'({wb_reg_we_o, wb_debug_have_inst_o, wb_wR_o, wb_wD_o}), 64'd0);
        exp_q.delete();
        err_model = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_one(mk(WB_SRC_MEM, ST_NONE, 1'b1, 1'b1, 5'd10, 32'h808, 32'h0, 2, 32'h5A5A_A5A5));

        for (int i = 0; i < 300; i++) begin
            a  = $urandom_range(0, 9);
            rw = 2'($urandom_range(0, 3));
            hi = ($urandom_range(0, 7) != 0);
            if (!hi && rw == WB_SRC_MEM) rw = WB_SRC_RESC;
            run_one(mk(rw, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), hi,
                       5'($urandom_range(0, 31)), $urandom, $urandom,
                       (a == 0) ? 0 : 1 + (a % 3), $urandom));
        end

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
